// File: rtl/sprite_blitter.sv
// Sprite blitter: copies a page-major texture sprite into a page-organised frame buffer with clipping.
// Compile-time option BLIT_MERGE_EN: read-modify-write (OR) merge instead of overwrite.
module sprite_blitter #(
  parameter int FB_W     = 128,
  parameter int FB_PAGES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] base_addr,
  input  logic [5:0] spr_w,
  input  logic [1:0] spr_pages,
  input  logic [6:0] dst_x,
  input  logic [2:0] dst_page,
`ifdef BLIT_MERGE_EN
  input  logic [7:0] fb_rdata,
`endif
  output logic [9:0] tex_addr,
  input  logic [7:0] tex_data,
  output logic       fb_we,
  output logic [9:0] fb_addr,
  output logic [7:0] fb_wdata,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, COPY, RD, WR, DONE} state_t;

`ifdef BLIT_MERGE_EN
  localparam state_t FIRST = RD;
`else
  localparam state_t FIRST = COPY;
`endif

  state_t     state, state_nx;
  logic [5:0] w_q;
  logic [1:0] pages_q;
  logic [6:0] x_q;
  logic [2:0] dpage_q;
  logic [5:0] col_q;
  logic [1:0] page_q;
  logic [8:0] col_abs;
  logic [4:0] page_abs;
  logic       clip;
  logic       last_byte;
  logic       row_end;
  logic       advance;
  logic       empty_in;
  logic [9:0] dst_idx;
`ifdef BLIT_MERGE_EN
  logic [7:0] tex_lat_q;
`endif

  // Destination bounds are tested at full width so an overhanging sprite never wraps.
  function automatic logic clipped(input logic [8:0] cabs, input logic [4:0] pabs);
    return (cabs >= 9'(FB_W)) || (pabs >= 5'(FB_PAGES));
  endfunction

  function automatic logic [9:0] fb_index(input logic [8:0] cabs, input logic [4:0] pabs);
    return 10'(pabs) * 10'(FB_W) + 10'(cabs);
  endfunction

  assign col_abs   = {2'b00, x_q} + {3'b000, col_q};
  assign page_abs  = {2'b00, dpage_q} + {3'b000, page_q};
  assign clip      = clipped(col_abs, page_abs);
  assign dst_idx   = fb_index(col_abs, page_abs);
  assign row_end   = ({1'b0, col_q} + 7'd1) == {1'b0, w_q};
  assign last_byte = row_end && (({1'b0, page_q} + 3'd1) == {1'b0, pages_q});
  assign empty_in  = (spr_w == 6'd0) || (spr_pages == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    fb_we    = 1'b0;
    fb_addr  = 10'd0;
    fb_wdata = 8'd0;
    busy     = 1'b0;
    done     = 1'b0;
    advance  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = empty_in ? DONE : FIRST;
      end
      COPY: begin
        busy     = 1'b1;
        fb_addr  = dst_idx;
        fb_wdata = tex_data;
        fb_we    = !clip;
        advance  = 1'b1;
        if (last_byte) state_nx = DONE;
      end
`ifdef BLIT_MERGE_EN
      RD: begin
        busy     = 1'b1;
        fb_addr  = dst_idx;
        state_nx = WR;
      end
      WR: begin
        busy     = 1'b1;
        fb_addr  = dst_idx;
        fb_wdata = tex_lat_q | fb_rdata;
        fb_we    = !clip;
        advance  = 1'b1;
        state_nx = last_byte ? DONE : RD;
      end
`endif
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // tex_addr doubles as the running texture pointer: bytes are fetched strictly in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q      <= 6'd0;
      pages_q  <= 2'd0;
      x_q      <= 7'd0;
      dpage_q  <= 3'd0;
      col_q    <= 6'd0;
      page_q   <= 2'd0;
      tex_addr <= 10'd0;
    end else if (state == IDLE && start) begin
      w_q      <= spr_w;
      pages_q  <= spr_pages;
      x_q      <= dst_x;
      dpage_q  <= dst_page;
      col_q    <= 6'd0;
      page_q   <= 2'd0;
      tex_addr <= base_addr;
    end else if (advance && !last_byte) begin
      tex_addr <= tex_addr + 10'd1;
      if (row_end) begin
        col_q  <= 6'd0;
        page_q <= page_q + 2'd1;
      end else begin
        col_q  <= col_q + 6'd1;
      end
    end
  end

`ifdef BLIT_MERGE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           tex_lat_q <= 8'd0;
    else if (state == RD) tex_lat_q <= tex_data;
  end
`endif

endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 Parameter FB_W, 128, frame-buffer width in columns.
REQ-002 Parameter FB_PAGES, 8, frame-buffer height in 8-pixel pages.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle request to blit; sampled only in IDLE.
REQ-006 base_addr  in  10  texture address of sprite byte 0.
REQ-007 spr_w  in  6  sprite width in columns (0..63).
REQ-008 spr_pages  in  2  sprite height in pages (0..3).
REQ-009 dst_x  in  7  destination column of sprite column 0.
REQ-010 dst_page  in  3  destination page of sprite page 0.
REQ-011 tex_addr  out  10  address to combinational texture ROM.
REQ-012 tex_data  in  8  ROM byte; valid same cycle as tex_addr; bit0 = top pixel.
REQ-013 fb_we  out  1  frame-buffer write strobe.
REQ-014 fb_addr  out  10  frame-buffer address = page*FB_W + column.
REQ-015 fb_wdata  out  8  frame-buffer write byte.
REQ-016 busy  out  1  high from cycle after accepted start until done.
REQ-017 done  out  1  one-cycle pulse on completion.

Function
REQ-018 States IDLE, COPY (plus RD/WR when merge compiled in, REQ-032), DONE; DONE lasts one cycle then returns to IDLE.
REQ-019 In IDLE, start=1 latches base_addr, spr_w, spr_pages, dst_x, dst_page, clears col/page counters, enters COPY; busy=1 next cycle.
REQ-020 If latched spr_w==0 or spr_pages==0: go directly to DONE, no fb_we.
REQ-021 Byte order page-major: sprite byte index = page*spr_w + col; tex_addr = base_addr + index, 10-bit wrap.
REQ-022 Traversal: col 0..spr_w-1 within page, then page+1; last byte is (spr_pages-1, spr_w-1).
REQ-023 Overwrite mode: one byte per cycle in COPY; fb_we=1, fb_wdata=tex_data, fb_addr=(dst_page+page)*FB_W+(dst_x+col) in same cycle.
REQ-024 Clipping: byte with dst_x+col >= FB_W or dst_page+page >= FB_PAGES (computed at full width, no wrap) gets fb_we=0; counters still advance.
REQ-025 Latency: N=spr_w*spr_pages bytes; overwrite mode done asserted N+1 cycles after the start cycle.
REQ-026 start while busy or in DONE is ignored, no queuing.
REQ-027 Outside byte-write cycles fb_we=0; tex_addr holds last value; fb_wdata/fb_addr don't-care when fb_we=0.

Reset
REQ-028 rst_n low forces IDLE immediately: busy=0, done=0, fb_we=0, tex_addr=0, fb_addr=0, fb_wdata=0, counters and latched operands 0.
REQ-029 Reset mid-blit aborts; no done pulse; remaining bytes never written.
REQ-030 First start honoured on first clk edge after rst_n deasserts.

Configuration
REQ-031 Macro BLIT_MERGE_EN selects merge mode at compile time.
REQ-032 With BLIT_MERGE_EN: extra input fb_rdata (8 bits, valid one cycle after fb_addr with fb_we=0); per byte RD cycle (fb_we=0, drive fb_addr, latch tex_data) then WR cycle (fb_we=1, fb_wdata=latched|fb_rdata); 2 cycles/byte, done N*2+1 cycles after start; clipped bytes still take 2 cycles, no write.
REQ-033 Without BLIT_MERGE_EN: no fb_rdata port; overwrite mode per REQ-023.

Verification
REQ-034 base_addr=0, spr_w=23, spr_pages=3, dst_x=10, dst_page=2 -> 69 writes, first fb_addr=266 data=ROM[0], last fb_addr=4*128+32=544 data=ROM[68], done at cycle 70.
REQ-035 spr_w=16, dst_x=120, spr_pages=1, dst_page=0 -> writes only cols 120..127 (8 writes), done at cycle 17.
REQ-036 spr_pages=3, dst_page=6 -> page 2 rows all suppressed; only pages 6,7 written.
REQ-037 spr_w=0 -> zero writes, done one cycle after entering DONE path; second start during busy ignored (single done).
REQ-038 rst_n low at byte 5 of a 48-byte blit -> outputs zero immediately, no done; new start completes normally.
REQ-039 BLIT_MERGE_EN, fb_rdata=8'h81, tex_data=8'h3c -> fb_wdata=8'hbd; 1x1 blit done at cycle 3.
